// File: rtl/hovalaag_pkg.sv
// Shared definitions for the Hovalaag host sequencer.
//   seq_state_t  : sequencer FSM states
//   ADDR_*       : one-hot bus_addr codes for the wrapper's beat/read strobes
//   STATUS_*     : bit positions inside the 4-bit status nibble
//   instr_chunk  : selects the 6-bit instruction slice written on beat W_Ik
package hovalaag_pkg;

    typedef enum logic [4:0] {
        ST_IDLE,
        ST_W_IN1L,
        ST_W_IN1H,
        ST_W_IN2L,
        ST_W_IN2H,
        ST_W_I0,
        ST_W_I1,
        ST_W_I2,
        ST_W_I3,
        ST_W_I4,
        ST_EXEC,
        ST_R_PC,
        ST_R_OUTL,
        ST_R_OUTH,
        ST_RESP,
        ST_CPURST
    } seq_state_t;

    localparam logic [9:0] ADDR_NONE   = 10'b00_0000_0000;
    localparam logic [9:0] ADDR_INSTR0 = 10'b00_0000_0001;
    localparam logic [9:0] ADDR_INSTR1 = 10'b00_0000_0010;
    localparam logic [9:0] ADDR_INSTR2 = 10'b00_0000_0100;
    localparam logic [9:0] ADDR_INSTR3 = 10'b00_0000_1000;
    localparam logic [9:0] ADDR_INSTR4 = 10'b00_0001_0000;
    localparam logic [9:0] ADDR_EXEC   = 10'b00_0010_0000;
    localparam logic [9:0] ADDR_IN1L   = 10'b00_0100_0000;
    localparam logic [9:0] ADDR_IN1H   = 10'b00_1000_0000;
    localparam logic [9:0] ADDR_IN2L   = 10'b01_0000_0000;
    localparam logic [9:0] ADDR_IN2H   = 10'b10_0000_0000;
    // Read strobes share lines with the IN write strobes.
    localparam logic [9:0] ADDR_PC     = 10'b00_0100_0000;
    localparam logic [9:0] ADDR_OUTL   = 10'b00_1000_0000;
    localparam logic [9:0] ADDR_OUTH   = 10'b01_0000_0000;

    localparam int unsigned STATUS_IN1_ADV    = 0;
    localparam int unsigned STATUS_IN2_ADV    = 1;
    localparam int unsigned STATUS_OUT1_VALID = 2;
    localparam int unsigned STATUS_OUT2_VALID = 3;

    function automatic logic [5:0] instr_chunk(input logic [31:0] instr, input logic [2:0] k);
        logic [5:0] c;
        case (k)
            3'd0:    c = instr[5:0];
            3'd1:    c = instr[11:6];
            3'd2:    c = instr[17:12];
            3'd3:    c = instr[23:18];
            3'd4:    c = instr[29:24];
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hovalaag_host_sequencer.sv
// Host-side driver for the Hovalaag wrapper bus (one-hot addr, 6-bit write
// data, 8-bit combinational read data). Takes one command per handshake,
// serialises IN1/IN2 and the instruction onto the bus, pulses execute once,
// reads back status/PC/OUT and returns a single response.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake (ready only in IDLE)
//   cmd_is_reset                command is a CPU reset (other fields ignored)
//   cmd_instr/cmd_in1/cmd_in2   instruction word and input values
//   bus_reset/bus_addr/bus_wdata/bus_rdata   wrapper pins
//   rsp_valid/rsp_ready         response handshake
//   rsp_status/rsp_pc/rsp_out   status nibble, PC and OUT after execute
module hovalaag_host_sequencer
    import hovalaag_pkg::*;
#(
    parameter bit          SKIP_UNCHANGED_IN = 1'b1,
    parameter int unsigned RESET_CYCLES      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_is_reset,
    input  logic [31:0] cmd_instr,
    input  logic [11:0] cmd_in1,
    input  logic [11:0] cmd_in2,
    output logic        bus_reset,
    output logic [9:0]  bus_addr,
    output logic [5:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [3:0]  rsp_status,
    output logic [7:0]  rsp_pc,
    output logic [11:0] rsp_out
);

    localparam int unsigned    RCW      = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RCW-1:0] RST_LAST = RCW'(RESET_CYCLES - 1);

    seq_state_t     state;
    seq_state_t     state_n;

    logic [31:0]    instr_q;
    logic [11:0]    in1_q;
    logic [11:0]    in2_q;
    logic           skip_in2_q;

    // Last values written to the wrapper's IN registers.
    logic [11:0]    in1_cache;
    logic [11:0]    in2_cache;
    logic           in1_cache_ok;
    logic           in2_cache_ok;

    logic [RCW-1:0] rst_cnt;

    logic           skip_in1;
    logic           skip_in2;

    always_comb begin
        skip_in1 = SKIP_UNCHANGED_IN && in1_cache_ok && (in1_cache == cmd_in1);
        skip_in2 = SKIP_UNCHANGED_IN && in2_cache_ok && (in2_cache == cmd_in2);
    end

    always_comb begin
        state_n   = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        bus_reset = 1'b0;
        bus_addr  = ADDR_NONE;
        bus_wdata = '0;

        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_is_reset)
                        state_n = ST_CPURST;
                    else if (!skip_in1)
                        state_n = ST_W_IN1L;
                    else if (!skip_in2)
                        state_n = ST_W_IN2L;
                    else
                        state_n = ST_W_I0;
                end
            end
            ST_W_IN1L: begin
                bus_addr  = ADDR_IN1L;
                bus_wdata = in1_q[5:0];
                state_n   = ST_W_IN1H;
            end
            ST_W_IN1H: begin
                bus_addr  = ADDR_IN1H;
                bus_wdata = in1_q[11:6];
                state_n   = skip_in2_q ? ST_W_I0 : ST_W_IN2L;
            end
            ST_W_IN2L: begin
                bus_addr  = ADDR_IN2L;
                bus_wdata = in2_q[5:0];
                state_n   = ST_W_IN2H;
            end
            ST_W_IN2H: begin
                bus_addr  = ADDR_IN2H;
                bus_wdata = in2_q[11:6];
                state_n   = ST_W_I0;
            end
            ST_W_I0: begin
                bus_addr  = ADDR_INSTR0;
                bus_wdata = instr_chunk(instr_q, 3'd0);
                state_n   = ST_W_I1;
            end
            ST_W_I1: begin
                bus_addr  = ADDR_INSTR1;
                bus_wdata = instr_chunk(instr_q, 3'd1);
                state_n   = ST_W_I2;
            end
            ST_W_I2: begin
                bus_addr  = ADDR_INSTR2;
                bus_wdata = instr_chunk(instr_q, 3'd2);
                state_n   = ST_W_I3;
            end
            ST_W_I3: begin
                bus_addr  = ADDR_INSTR3;
                bus_wdata = instr_chunk(instr_q, 3'd3);
                state_n   = ST_W_I4;
            end
            ST_W_I4: begin
                bus_addr  = ADDR_INSTR4;
                bus_wdata = instr_chunk(instr_q, 3'd4);
                state_n   = ST_EXEC;
            end
            ST_EXEC: begin
                // Top two instruction bits ride along with the execute strobe.
                bus_addr  = ADDR_EXEC;
                bus_wdata = {4'b0000, instr_q[31:30]};
                state_n   = ST_R_PC;
            end
            ST_R_PC: begin
                bus_addr = ADDR_PC;
                state_n  = ST_R_OUTL;
            end
            ST_R_OUTL: begin
                bus_addr = ADDR_OUTL;
                state_n  = ST_R_OUTH;
            end
            ST_R_OUTH: begin
                bus_addr = ADDR_OUTH;
                state_n  = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_n = ST_IDLE;
            end
            ST_CPURST: begin
                bus_reset = 1'b1;
                if (rst_cnt == RST_LAST)
                    state_n = ST_RESP;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            instr_q      <= '0;
            in1_q        <= '0;
            in2_q        <= '0;
            skip_in2_q   <= 1'b0;
            in1_cache    <= '0;
            in2_cache    <= '0;
            in1_cache_ok <= 1'b0;
            in2_cache_ok <= 1'b0;
            rst_cnt      <= '0;
            rsp_status   <= '0;
            rsp_pc       <= '0;
            rsp_out      <= '0;
        end else begin
            state <= state_n;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        instr_q    <= cmd_instr;
                        in1_q      <= cmd_in1;
                        in2_q      <= cmd_in2;
                        skip_in2_q <= skip_in2;
                        rst_cnt    <= '0;
                        if (cmd_is_reset) begin
                            rsp_status <= '0;
                            rsp_pc     <= '0;
                            rsp_out    <= '0;
                        end
                    end
                end
                ST_W_IN1H: begin
                    in1_cache    <= in1_q;
                    in1_cache_ok <= 1'b1;
                end
                ST_W_IN2H: begin
                    in2_cache    <= in2_q;
                    in2_cache_ok <= 1'b1;
                end
                // Status is the wrapper's view before the CPU clock edge.
                ST_EXEC:   rsp_status    <= bus_rdata[3:0];
                ST_R_PC:   rsp_pc        <= bus_rdata;
                ST_R_OUTL: rsp_out[7:0]  <= bus_rdata;
                ST_R_OUTH: rsp_out[11:8] <= bus_rdata[3:0];
                ST_CPURST: begin
                    // The wrapper clears in1/in2 on CPU reset.
                    rst_cnt      <= rst_cnt + RCW'(1);
                    in1_cache_ok <= 1'b0;
                    in2_cache_ok <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hovalaag_host_sequencer.sv
module tb_hovalaag_host_sequencer;
    import hovalaag_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_is_reset = 1'b0;
    logic [31:0] cmd_instr = '0;
    logic [11:0] cmd_in1 = '0;
    logic [11:0] cmd_in2 = '0;
    logic        bus_reset;
    logic [9:0]  bus_addr;
    logic [5:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [3:0]  rsp_status;
    logic [7:0]  rsp_pc;
    logic [11:0] rsp_out;

    always #5 clk = ~clk;

    hovalaag_host_sequencer #(
        .SKIP_UNCHANGED_IN(1'b1),
        .RESET_CYCLES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_is_reset(cmd_is_reset),
        .cmd_instr(cmd_instr),
        .cmd_in1(cmd_in1),
        .cmd_in2(cmd_in2),
        .bus_reset(bus_reset),
        .bus_addr(bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_status(rsp_status),
        .rsp_pc(rsp_pc),
        .rsp_out(rsp_out)
    );

    // Toy wrapper peer: instr[27:24] is the status nibble, instr[29] loads
    // W from IN2, instr[28] loads W from IN1, every execute bumps PC.
    // IN writes are honoured only before execute, so the read strobes that
    // share lines with them do not clobber IN1/IN2.
    logic [31:0] w_instr = '0;
    logic [11:0] w_in1 = '0;
    logic [11:0] w_in2 = '0;
    logic [11:0] w_acc = '0;
    logic [7:0]  w_pc = '0;
    logic        w_wr = 1'b1;

    always @(posedge clk) begin
        if (bus_reset) begin
            w_instr <= '0;
            w_in1   <= '0;
            w_in2   <= '0;
            w_acc   <= '0;
            w_pc    <= '0;
            w_wr    <= 1'b1;
        end else begin
            for (int k = 0; k < 5; k++)
                if (bus_addr[k]) w_instr[6*k +: 6] <= bus_wdata;
            if (w_wr) begin
                if (bus_addr[6]) w_in1[5:0]  <= bus_wdata;
                if (bus_addr[7]) w_in1[11:6] <= bus_wdata;
                if (bus_addr[8]) w_in2[5:0]  <= bus_wdata;
                if (bus_addr[9]) w_in2[11:6] <= bus_wdata;
            end
            if (bus_addr[5]) begin
                w_instr[31:30] <= bus_wdata[1:0];
                w_pc           <= w_pc + 8'd1;
                if (w_instr[29])      w_acc <= w_in2;
                else if (w_instr[28]) w_acc <= w_in1;
                w_wr <= 1'b0;
            end else if (bus_addr == ADDR_NONE) begin
                w_wr <= 1'b1;
            end
        end
    end

    always_comb begin
        bus_rdata = '0;
        if (bus_addr == ADDR_EXEC)      bus_rdata = {4'b0000, w_instr[27:24]};
        else if (bus_addr == ADDR_PC)   bus_rdata = w_pc;
        else if (bus_addr == ADDR_OUTL) bus_rdata = w_acc[7:0];
        else if (bus_addr == ADDR_OUTH) bus_rdata = {4'b0000, w_acc[11:8]};
    end

    // Bus monitor.
    int   exec_count = 0;
    int   double_exec = 0;
    int   bad_addr = 0;
    int   rst_run = 0;
    int   last_rst_len = 0;
    logic prev_exec = 1'b0;

    always @(negedge clk) begin
        if (bus_addr[5]) begin
            exec_count++;
            if (prev_exec) double_exec++;
        end
        prev_exec = bus_addr[5];
        if ($countones(bus_addr) > 1) bad_addr++;
        if (bus_reset) rst_run++;
        else if (rst_run != 0) begin
            last_rst_len = rst_run;
            rst_run = 0;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    logic [9:0] tr_addr [16];
    logic [5:0] tr_wdata [16];

    // Returns the number of busy cycles between the accept edge and the
    // first cycle with rsp_valid. Leaves time at #1 after that edge.
    task automatic do_cmd(input logic isr, input logic [31:0] instr, input logic [11:0] in1,
                          input logic [11:0] in2, input logic early, output int busy);
        int guard;
        cmd_valid    = 1'b1;
        cmd_is_reset = isr;
        cmd_instr    = instr;
        cmd_in1      = in1;
        cmd_in2      = in2;
        rsp_ready    = early;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("accept_ready", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        cmd_valid    = 1'b0;
        cmd_is_reset = 1'b0;
        cmd_instr    = '0;
        busy = 0;
        while (!rsp_valid && busy < 40) begin
            if (busy < 16) begin
                tr_addr[busy]  = bus_addr;
                tr_wdata[busy] = bus_wdata;
            end
            busy++;
            @(posedge clk); #1;
        end
        if (!rsp_valid) chk("rsp_timeout", {31'b0, rsp_valid}, 32'd1);
    endtask

    typedef struct {
        logic        is_rst;
        logic [31:0] instr;
        logic [11:0] in1;
        logic [11:0] in2;
        logic        early;
        int          busy;
        logic [3:0]  status;
        logic [7:0]  pc;
        logic [11:0] out;
        logic        hold;
    } vec_t;

    vec_t vecs [7];

    logic [9:0] exp_a [13] = '{ADDR_IN1L, ADDR_IN1H, ADDR_IN2L, ADDR_IN2H,
                               ADDR_INSTR0, ADDR_INSTR1, ADDR_INSTR2, ADDR_INSTR3, ADDR_INSTR4,
                               ADDR_EXEC, ADDR_PC, ADDR_OUTL, ADDR_OUTH};
    logic [5:0] exp_w [13] = '{6'h23, 6'h04, 6'h16, 6'h11,
                               6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    initial begin
        int busy;

        vecs[0] = '{1'b0, 32'h0000_0000, 12'h123, 12'h456, 1'b1, 13, 4'h0, 8'd1, 12'h000, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0000, 12'h123, 12'h456, 1'b0,  9, 4'h0, 8'd2, 12'h000, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0000, 12'h123, 12'h789, 1'b1, 11, 4'h0, 8'd3, 12'h000, 1'b0};
        vecs[3] = '{1'b1, 32'h0000_0000, 12'h000, 12'h000, 1'b0,  2, 4'h0, 8'd0, 12'h000, 1'b0};
        vecs[4] = '{1'b0, 32'h1412_3456, 12'h123, 12'h789, 1'b0, 13, 4'h4, 8'd1, 12'h123, 1'b0};
        vecs[5] = '{1'b0, 32'h2ABC_DEF5, 12'h123, 12'h789, 1'b1,  9, 4'hA, 8'd2, 12'h789, 1'b0};
        vecs[6] = '{1'b0, 32'hC3A5_5A3C, 12'h0AA, 12'h789, 1'b0, 11, 4'h3, 8'd3, 12'h789, 1'b1};

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_bus_addr", {22'b0, bus_addr}, 32'd0);
        chk("rst_bus_wdata", {26'b0, bus_wdata}, 32'd0);
        chk("rst_bus_reset", {31'b0, bus_reset}, 32'd0);
        chk("rst_rsp_data", {8'b0, rsp_status, rsp_pc, rsp_out}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            do_cmd(vecs[i].is_rst, vecs[i].instr, vecs[i].in1, vecs[i].in2, vecs[i].early, busy);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].busy);
            chk($sformatf("v%0d_status", i), {28'b0, rsp_status}, {28'b0, vecs[i].status});
            chk($sformatf("v%0d_pc", i), {24'b0, rsp_pc}, {24'b0, vecs[i].pc});
            chk($sformatf("v%0d_out", i), {20'b0, rsp_out}, {20'b0, vecs[i].out});
            if (!vecs[i].is_rst)
                chk($sformatf("v%0d_wrapper_instr", i), w_instr, vecs[i].instr);
            if (i == 0) begin
                for (int b = 0; b < 13; b++) begin
                    chk($sformatf("trace_addr%0d", b), {22'b0, tr_addr[b]}, {22'b0, exp_a[b]});
                    chk($sformatf("trace_wdata%0d", b), {26'b0, tr_wdata[b]}, {26'b0, exp_w[b]});
                end
            end
            if (vecs[i].hold) begin
                rsp_ready = 1'b0;
                for (int h = 0; h < 5; h++) begin
                    @(posedge clk); #1;
                    chk($sformatf("hold%0d_flags", h), {30'b0, rsp_valid, cmd_ready}, 32'd2);
                    chk($sformatf("hold%0d_data", h), {8'b0, rsp_status, rsp_pc, rsp_out},
                        {8'b0, vecs[i].status, vecs[i].pc, vecs[i].out});
                end
            end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            chk($sformatf("v%0d_release", i), {30'b0, rsp_valid, cmd_ready}, 32'd1);
            if (vecs[i].is_rst)
                chk("cpurst_len", last_rst_len, 32'd2);
        end

        // Sequencer reset in the middle of the instruction beats.
        cmd_valid = 1'b1;
        cmd_instr = 32'hFFFF_FFFF;
        cmd_in1   = 12'h0AA;
        cmd_in2   = 12'h789;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_at_i2", {22'b0, bus_addr}, {22'b0, ADDR_INSTR2});
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_bus_addr", {22'b0, bus_addr}, 32'd0);
        chk("abort_flags", {30'b0, rsp_valid, cmd_ready}, 32'd1);
        chk("abort_rsp_pc", {24'b0, rsp_pc}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_exec", exec_count, 32'd6);

        // Caches were dropped by the reset, so both IN pairs are rewritten.
        do_cmd(1'b0, 32'h0000_0041, 12'h0AA, 12'h789, 1'b1, busy);
        chk("post_abort_busy", busy, 32'd13);
        chk("post_abort_pc", {24'b0, rsp_pc}, 32'd4);
        chk("post_abort_out", {20'b0, rsp_out}, 32'h789);
        chk("post_abort_instr", w_instr, 32'h0000_0041);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("total_exec", exec_count, 32'd7);
        chk("double_exec", double_exec, 32'd0);
        chk("addr_onehot", bad_addr, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
